// File: rtl/seg_display_scheduler.sv
// seg_display_scheduler
//   Shares one 4-digit seven-segment display between three producers
//   (ultrasonic distance, motor speed, LFSR debug value). Requests are
//   latched into pending bits and shadow registers. The display is granted
//   round-robin, and each grant is held for a minimum time. The granted value
//   is converted to BCD one bit per clock (shift-add-3), and the result drives
//   the multiplexed AN/seg scan.
//
// Ports
//   clk         system clock
//   rst         synchronous reset, active-low
//   req_dist    1-cycle pulse, samples distance[19:0]
//   req_speed   1-cycle pulse, samples speed[1:0]
//   req_lfsr    1-cycle pulse, samples lfsr[3:0]
//   seg[6:0]    active-low segments, gfedcba (registered)
//   AN[3:0]     active-low digit enables (registered)
//   grant[2:0]  one-hot 1-cycle grant pulse: bit0 dist, bit1 speed, bit2 lfsr
//   active_src  source on display: 0 none, 1 dist, 2 speed, 3 lfsr
//   busy        high while converting
module seg_display_scheduler #(
  parameter int unsigned SCAN_BITS   = 17,
  parameter int unsigned HOLD_CYCLES = 50000000,
  parameter int unsigned HOLD_W      = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_dist,
  input  logic [19:0] distance,
  input  logic        req_speed,
  input  logic [1:0]  speed,
  input  logic        req_lfsr,
  input  logic [3:0]  lfsr,
  output logic [6:0]  seg,
  output logic [3:0]  AN,
  output logic [2:0]  grant,
  output logic [1:0]  active_src,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONVERT,
    S_SHOW
  } state_t;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [1:0]        SRC_NONE  = 2'd0;
  localparam logic [1:0]        SRC_SPEED = 2'd2;
  localparam logic [1:0]        SRC_LFSR  = 2'd3;

  state_t state, state_nx;

  // Request capture
  logic [2:0]  pending;
  logic [19:0] sh_dist;
  logic [1:0]  sh_speed;
  logic [3:0]  sh_lfsr;

  // Arbitration. last_idx is the index of the last winner (0 dist, 1 speed,
  // 2 lfsr). Its reset value is lfsr, so the first search starts at dist.
  logic [1:0]  last_idx;
  logic [1:0]  arb_idx;
  logic        arb_fire;

  // Hold timer
  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_done;

  // Conversion
  logic [1:0]  conv_src;
  logic [13:0] conv_op;
  logic [15:0] conv_bcd;
  logic [3:0]  conv_iter;
  logic        conv_last;
  logic [15:0] bcd_shift;
  logic [15:0] conv_result;
  logic [13:0] dist_clamped;

  // Display
  logic [15:0] disp_digits, disp_digits_nx;
  logic [1:0]  disp_src, disp_src_nx;
  logic [SCAN_BITS-1:0] scan_cnt, scan_nx;
  logic [1:0]  sel_nx;
  logic [3:0]  digit_nx;
  logic        blank_nx;
  logic [3:0]  an_nx;
  logic [6:0]  seg_nx;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------- arbiter
  always_comb begin
    arb_idx = 2'd0;
    case (last_idx)
      2'd0: begin
        if (pending[1])      arb_idx = 2'd1;
        else if (pending[2]) arb_idx = 2'd2;
        else                 arb_idx = 2'd0;
      end
      2'd1: begin
        if (pending[2])      arb_idx = 2'd2;
        else if (pending[0]) arb_idx = 2'd0;
        else                 arb_idx = 2'd1;
      end
      default: begin
        if (pending[0])      arb_idx = 2'd0;
        else if (pending[1]) arb_idx = 2'd1;
        else                 arb_idx = 2'd2;
      end
    endcase
  end

  assign hold_done = (hold_cnt == HOLD_LAST);
  assign arb_fire  = (|pending) &&
                     ((state == S_IDLE) || ((state == S_SHOW) && hold_done));
  assign grant     = arb_fire ? (3'b001 << arb_idx) : 3'b000;
  assign busy      = (state == S_CONVERT);

  assign dist_clamped = (sh_dist > 20'd9999) ? 14'd9999 : sh_dist[13:0];

  // ---------------------------------------------------------- double dabble
  // The top nibble keeps only 3 bits after adjust, because its MSB is shifted
  // out. For operands up to 9999 that nibble never needs the carry.
  always_comb begin
    logic [11:0] adj_lo;
    logic [2:0]  adj_top;
    adj_lo = conv_bcd[11:0];
    for (int unsigned d = 0; d < 3; d++) begin
      if (conv_bcd[4*d +: 4] >= 4'd5)
        adj_lo[4*d +: 4] = conv_bcd[4*d +: 4] + 4'd3;
    end
    adj_top   = conv_bcd[14:12] + ((conv_bcd[15:12] >= 4'd5) ? 3'd3 : 3'd0);
    bcd_shift = {adj_top, adj_lo, conv_op[13]};
  end

  assign conv_last = (state == S_CONVERT) &&
                     ((conv_src == SRC_LFSR) || (conv_iter == 4'd13));

  assign conv_result = (conv_src == SRC_LFSR)
                     ? {3'b000, conv_op[3], 3'b000, conv_op[2],
                        3'b000, conv_op[1], 3'b000, conv_op[0]}
                     : bcd_shift;

  // --------------------------------------------------------- next-state FSM
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (arb_fire)  state_nx = S_CONVERT;
      S_CONVERT: if (conv_last) state_nx = S_SHOW;
      S_SHOW:    if (arb_fire)  state_nx = S_CONVERT;
      default:   state_nx = S_IDLE;
    endcase
  end

  // ----------------------------------------------------------- display path
  // seg/AN are computed from the values that the digit registers and the scan
  // counter take on this edge. A finished conversion is therefore visible on
  // the same edge that commits it.
  always_comb begin
    disp_digits_nx = conv_last ? conv_result : disp_digits;
    disp_src_nx    = conv_last ? conv_src    : disp_src;
    scan_nx        = scan_cnt + 1'b1;
    sel_nx         = scan_nx[SCAN_BITS-1 -: 2];
    digit_nx       = disp_digits_nx[{sel_nx, 2'b00} +: 4];
    blank_nx       = (disp_src_nx == SRC_NONE) ||
                     ((disp_src_nx == SRC_SPEED) && (sel_nx != 2'd0));
    an_nx          = (disp_src_nx == SRC_NONE) ? 4'b1111 : ~(4'b0001 << sel_nx);
    seg_nx         = blank_nx ? 7'b1111111 : seg_of(digit_nx);
  end

  // ------------------------------------------------------------- registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      pending     <= '0;
      sh_dist     <= '0;
      sh_speed    <= '0;
      sh_lfsr     <= '0;
      last_idx    <= 2'd2;
      hold_cnt    <= '0;
      conv_src    <= '0;
      conv_op     <= '0;
      conv_bcd    <= '0;
      conv_iter   <= '0;
      disp_digits <= '0;
      disp_src    <= '0;
      scan_cnt    <= '0;
      AN          <= '1;
      seg         <= '1;
    end else begin
      state    <= state_nx;
      scan_cnt <= scan_nx;

      // A request in the same cycle as its own grant keeps the bit set.
      // The grant has already used the pre-edge shadow.
      pending <= (pending & ~grant) | {req_lfsr, req_speed, req_dist};
      if (req_dist)  sh_dist  <= distance;
      if (req_speed) sh_speed <= speed;
      if (req_lfsr)  sh_lfsr  <= lfsr;

      if (arb_fire) begin
        last_idx  <= arb_idx;
        conv_src  <= 2'(arb_idx + 2'd1);
        conv_iter <= '0;
        conv_bcd  <= '0;
        case (arb_idx)
          2'd0:    conv_op <= dist_clamped;
          2'd1:    conv_op <= {12'd0, sh_speed};
          default: conv_op <= {10'd0, sh_lfsr};
        endcase
      end else if (state == S_CONVERT) begin
        conv_iter <= conv_iter + 4'd1;
        conv_bcd  <= bcd_shift;
        conv_op   <= {conv_op[12:0], 1'b0};
      end

      if (conv_last)
        hold_cnt <= '0;
      else if ((state == S_SHOW) && !hold_done)
        hold_cnt <= hold_cnt + HOLD_W'(1);

      disp_digits <= disp_digits_nx;
      disp_src    <= disp_src_nx;
      AN          <= an_nx;
      seg         <= seg_nx;
    end
  end

  assign active_src = disp_src;

endmodule

// File: tb/tb_seg_display_scheduler.sv
module tb_seg_display_scheduler;

  localparam int unsigned HOLD = 8;

  localparam logic [6:0] D0 = 7'b1000000;
  localparam logic [6:0] D1 = 7'b1111001;
  localparam logic [6:0] D2 = 7'b0100100;
  localparam logic [6:0] D3 = 7'b0110000;
  localparam logic [6:0] D4 = 7'b0011001;
  localparam logic [6:0] D5 = 7'b0010010;
  localparam logic [6:0] D6 = 7'b0000010;
  localparam logic [6:0] D7 = 7'b1111000;
  localparam logic [6:0] D8 = 7'b0000000;
  localparam logic [6:0] D9 = 7'b0010000;
  localparam logic [6:0] BL = 7'b1111111;

  logic        clk, rst;
  logic        req_dist, req_speed, req_lfsr;
  logic [19:0] distance;
  logic [1:0]  speed;
  logic [3:0]  lfsr;
  logic [6:0]  seg;
  logic [3:0]  AN;
  logic [2:0]  grant;
  logic [1:0]  active_src;
  logic        busy;

  typedef struct {
    logic [2:0]      g;
    int unsigned     blen;
    logic [1:0]      src;
    logic [3:0][6:0] segs;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  logic        rst_abort = 1'b0;

  seg_display_scheduler #(
    .SCAN_BITS(3),
    .HOLD_CYCLES(HOLD),
    .HOLD_W(4)
  ) dut (
    .clk(clk), .rst(rst),
    .req_dist(req_dist), .distance(distance),
    .req_speed(req_speed), .speed(speed),
    .req_lfsr(req_lfsr), .lfsr(lfsr),
    .seg(seg), .AN(AN), .grant(grant),
    .active_src(active_src), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic exp_t mk(input logic [2:0] g, input int unsigned blen, input logic [1:0] src,
                              input logic [6:0] s3, input logic [6:0] s2,
                              input logic [6:0] s1, input logic [6:0] s0);
    exp_t e;
    e.g = g; e.blen = blen; e.src = src;
    e.segs = {s3, s2, s1, s0};
    return e;
  endfunction

  // Monitor: each grant pops one expectation and follows that transaction.
  initial begin : monitor
    exp_t        e;
    int unsigned n, fall_cyc, d, shown;
    logic        have_prev, aborted, first;
    logic [3:0]  seen;
    have_prev = 1'b0;
    fall_cyc  = 0;
    forever begin
      @(negedge clk);
      if (!rst || rst_abort) begin
        have_prev = 1'b0;
      end else if (grant != 3'b000) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_grant: got %b expected none", grant);
        end else begin
          e = exp_q.pop_front();
          chk("grant", grant, e.g);
          if (have_prev) begin
            shown = cyc - fall_cyc + 1;
            checks++;
            if (shown < HOLD) begin
              errors++;
              $display("FAIL hold_time: got %0d show cycles expected >= %0d", shown, HOLD);
            end
          end
          n = 0; aborted = 1'b0; first = 1'b1;
          do begin
            @(negedge clk);
            if (!rst || rst_abort) aborted = 1'b1;
            else begin
              if (first) chk("grant_pulse", grant, 3'b000);
              first = 1'b0;
              if (busy) n++;
            end
          end while (!aborted && busy && n < 64);
          if (aborted) have_prev = 1'b0;
          else begin
            chk("busy_len", n, e.blen);
            fall_cyc  = cyc;
            have_prev = 1'b1;
            chk("active_src", active_src, e.src);
            seen = 4'b0000;
            for (int s = 0; s < 7; s++) begin
              if (s > 0) @(negedge clk);
              if (!rst || rst_abort) begin aborted = 1'b1; break; end
              case (AN)
                4'b1110: d = 0;
                4'b1101: d = 1;
                4'b1011: d = 2;
                4'b0111: d = 3;
                default: d = 4;
              endcase
              if (d == 4) begin
                checks++; errors++;
                $display("FAIL an_pattern: got %b expected one active digit", AN);
              end else begin
                seen[d] = 1'b1;
                chk($sformatf("seg_digit%0d", d), seg, e.segs[d]);
              end
            end
            if (aborted) have_prev = 1'b0;
            else chk("digits_covered", seen, 4'hF);
          end
        end
      end
    end
  end

  task automatic wait_idle();
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < 300) begin @(negedge clk); n++; end
    chk("queue_drained", exp_q.size(), 0);
    repeat (30) @(negedge clk);
  endtask

  task automatic wait_busy(input logic lvl, input string name);
    int unsigned n = 0;
    while (busy !== lvl && n < 64) begin @(negedge clk); n++; end
    chk(name, busy, lvl);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_AN"}, AN, 4'b1111);
    chk({tag, "_seg"}, seg, BL);
    chk({tag, "_active_src"}, active_src, 2'd0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_grant"}, grant, 3'b000);
  endtask

  task automatic send_dist(input logic [19:0] v, input exp_t e);
    @(negedge clk);
    req_dist = 1'b1; distance = v;
    exp_q.push_back(e);
    @(negedge clk);
    req_dist = 1'b0;
  endtask

  initial begin : stimulus
    rst = 1'b0;
    req_dist = 1'b0; req_speed = 1'b0; req_lfsr = 1'b0;
    distance = '0; speed = '0; lfsr = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;

    // Idle: display stays blank with no requests.
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      chk("idle_AN", AN, 4'b1111);
      chk("idle_seg", seg, BL);
      chk("idle_src", active_src, 2'd0);
    end

    // All three at once: round-robin from dist, each held HOLD cycles.
    @(negedge clk);
    req_dist = 1'b1; distance = 20'd567;
    req_speed = 1'b1; speed = 2'd3;
    req_lfsr = 1'b1; lfsr = 4'b0110;
    exp_q.push_back(mk(3'b001, 14, 2'd1, D0, D5, D6, D7));
    exp_q.push_back(mk(3'b010, 14, 2'd2, BL, BL, BL, D3));
    exp_q.push_back(mk(3'b100, 1,  2'd3, D0, D1, D1, D0));
    @(negedge clk);
    req_dist = 1'b0; req_speed = 1'b0; req_lfsr = 1'b0;
    wait_idle();

    send_dist(20'd1234,  mk(3'b001, 14, 2'd1, D1, D2, D3, D4));
    wait_idle();
    send_dist(20'd50000, mk(3'b001, 14, 2'd1, D9, D9, D9, D9));
    wait_idle();
    send_dist(20'd9998,  mk(3'b001, 14, 2'd1, D9, D9, D9, D8));
    wait_idle();

    // Speed shown, then an lfsr request early in SHOW must wait for hold.
    @(negedge clk);
    req_speed = 1'b1; speed = 2'd2;
    exp_q.push_back(mk(3'b010, 14, 2'd2, BL, BL, BL, D2));
    @(negedge clk);
    req_speed = 1'b0;
    wait_busy(1'b1, "speed_busy_rise");
    wait_busy(1'b0, "speed_busy_fall");
    repeat (2) @(negedge clk);
    req_lfsr = 1'b1; lfsr = 4'b1010;
    exp_q.push_back(mk(3'b100, 1, 2'd3, D1, D0, D1, D0));
    @(negedge clk);
    req_lfsr = 1'b0;
    wait_idle();

    // Reset in the middle of a dist conversion.
    send_dist(20'd1234, mk(3'b001, 14, 2'd1, D1, D2, D3, D4));
    wait_busy(1'b1, "rst_busy_rise");
    repeat (4) @(negedge clk);
    rst_abort = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst_abort = 1'b0;
    repeat (12) @(negedge clk);
    chk("midrst_src_stays", active_src, 2'd0);

    @(negedge clk);
    req_speed = 1'b1; speed = 2'd1;
    exp_q.push_back(mk(3'b010, 14, 2'd2, BL, BL, BL, D1));
    @(negedge clk);
    req_speed = 1'b0;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_display_scheduler.md
Name: seg_display_scheduler

Overview:
- Shares the single 4-digit seven-segment display between three producers: ultrasonic distance, motor speed and LFSR debug value.
- Latches each producer's update request and grants the display round-robin, with a minimum hold time per grant.
- Converts the granted value to BCD sequentially (shift-add-3, no divide/modulo) and drives the multiplexed AN/seg scan.
- Sits between the sensor/motor/LFSR blocks and the board display pins.

Parameters:
- SCAN_BITS, 17: scan counter width; digit select = scan_cnt[SCAN_BITS-1:SCAN_BITS-2].
- HOLD_CYCLES, 50000000: minimum clk cycles a granted source stays displayed. Must be ≥2.
- HOLD_W, 26: hold counter width. Must satisfy 2^HOLD_W > HOLD_CYCLES.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-low (rst==0 resets on the clk edge)
- req_dist  input  1  one-cycle pulse: new distance value
- distance  input  20  distance value, sampled when req_dist=1
- req_speed  input  1  one-cycle pulse: new speed value
- speed  input  2  speed value, sampled when req_speed=1
- req_lfsr  input  1  one-cycle pulse: new LFSR value
- lfsr  input  4  LFSR value, sampled when req_lfsr=1
- seg  output  7  active-low segments, gfedcba
- AN  output  4  active-low digit enables
- grant  output  3  one-hot, one-cycle grant pulse; bit0 = dist, bit1 = speed, bit2 = lfsr
- active_src  output  2  source currently shown: 0 none, 1 dist, 2 speed, 3 lfsr
- busy  output  1  high while in CONVERT

Behaviour:
- Reset values (rst==0):
  - state IDLE; all pending bits, shadow registers, BCD/display registers and scan_cnt cleared.
  - seg=7'b1111111, AN=4'b1111, grant=0, active_src=0, busy=0.
  - The display stays blank until the first conversion completes.
- Request capture:
  - A request pulse sets that source's pending bit and loads its shadow register. The latest value wins.
  - Capture works in every state.
  - If a request and a grant of the same source occur in the same cycle, the pending bit stays set and the shadow takes the new value. The grant uses the pre-edge shadow.
- States: IDLE, CONVERT, SHOW.
  - IDLE: when any pending bit is set, arbitrate and go to CONVERT.
  - SHOW: hold counter counts to HOLD_CYCLES-1, then saturates (hold_done). When hold_done and any pending bit is set, arbitrate and go to CONVERT. Otherwise remain in SHOW; the display never blanks.
- Arbitration:
  - Round-robin in order dist → speed → lfsr, starting after the last granted source. After reset, the search starts at dist.
  - The arbitration cycle asserts grant (one-hot, 1 cycle), clears the winner's pending bit and copies its shadow into the operand.
- CONVERT (busy=1):
  - dist: operand = min(distance, 9999), 14 bits.
  - speed: operand = zero-extended speed.
  - dist/speed: 14 shift-add-3 iterations, one per clk. CONVERT lasts exactly 14 cycles.
  - lfsr: digits loaded directly, digit i = lfsr[i] (0 or 1). CONVERT lasts 1 cycle.
  - The previous display keeps running unchanged throughout CONVERT.
- CONVERT exit:
  - Display digits and active_src update atomically on the last CONVERT edge.
  - The hold counter clears; state goes to SHOW.
- Latency: grant cycle N → new digits visible from edge N+15 (dist/speed) or N+2 (lfsr).
- Blanking:
  - speed: only digit0 is shown; digits 1-3 are blanked (seg=7'b1111111).
  - dist: leading zeros are shown.
- Scan:
  - scan_cnt free-runs in all states except reset.
  - Select 00 → AN=1110, digit0 (ones). 01 → 1101, digit1. 10 → 1011, digit2. 11 → 0111, digit3.
  - AN and seg are registered and change on the same edge.
- Segment table, digits 0-9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000. Blank = 1111111.
- Reset mid-CONVERT or mid-SHOW aborts everything; all registers return to their reset values.

Test Plan:
- Release reset, no requests, 2^SCAN_BITS cycles: AN/seg stay 1111/1111111; active_src=0; grant never asserts.
- req_dist with distance=1234: grant=001 for 1 cycle; busy high for exactly 14 cycles; then digit0..3 show 4,3,2,1 (seg 0011001, 0110000, 0100100, 1111001); active_src=1.
- req_dist with distance=20'd50000: all four digits show 9 (seg 0010000). Repeat with 9998: digits 8,9,9,9.
- HOLD_CYCLES=8, all three reqs pulsed together: grants in order 001, 010, 100. Each grant starts its CONVERT no earlier than 8 SHOW cycles after the previous conversion ends.
- Speed=2 shown, then req_lfsr with lfsr=4'b1010 during SHOW: lfsr is granted only after hold_done. Digits then show 0,1,0,1 on AN0..AN3; busy is high for 1 cycle.
- Drive rst=0 for one edge in the middle of a dist CONVERT: next cycle all outputs are at reset values and pending bits are clear. A subsequent req_speed=1 shows 1 on digit0 only.
